// File: rtl/pc_sequencer.sv
// pc_sequencer -- next-PC controller for the pipelined MIPS core.
//
// Picks the value the PC register loads on the next edge. Sources, highest
// priority first: exception entry, ERET return, a buffered (pending)
// redirect, a D-stage branch/jump redirect, and sequential fetch (PC+4).
// While the hazard unit stalls F/D the PC holds. A branch that shows up
// during a stall is buffered and applied on the first unstalled cycle.
//
// Optional feature: define PC_SEQ_EXC_EN to enable exception/ERET handling.
// When it is undefined, exc_req/eret_req/epc are ignored and flush_fd is
// only asserted during Reset.
//
// Ports:
//   clk, Reset     clock, synchronous active-high reset
//   PC             current PC register value (F-stage address)
//   stall          hazard-unit freeze of F/D; PC must hold
//   br_req         D-stage branch taken / jump, valid this cycle
//   br_target      branch/jump target
//   exc_req        CP0 exception/interrupt accepted
//   eret_req       ERET in M stage
//   epc            CP0 EPC value
//   NPC            value the PC register loads next edge (combinational)
//   flush_fd       clear F/D register (exception/ERET, and during Reset)
//   pend_valid     a buffered redirect is waiting
//   addr_misalign  NPC[1:0] != 0 (informational)
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter int          PEND_DEPTH = 1
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [31:0] PC,
  input  logic        stall,
  input  logic        br_req,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] NPC,
  output logic        flush_fd,
  output logic        pend_valid,
  output logic        addr_misalign
);

  // Only a single-entry pending buffer exists: a second redirect cannot
  // arrive before the first one's delay slot has been fetched.
  generate
    if (PEND_DEPTH != 1) begin : g_bad_depth
      $error("pc_sequencer: PEND_DEPTH must be 1");
    end
  endgenerate

  typedef enum logic [1:0] {S_RUN, S_HOLD, S_PEND} state_e;

  state_e      state_q, state_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic [31:0] npc;
  logic        flush;
  logic [31:0] pc_inc;
  logic        exc_take;
  logic        eret_take;

`ifdef PC_SEQ_EXC_EN
  assign exc_take  = exc_req;
  assign eret_take = eret_req;
`else
  assign exc_take  = 1'b0;
  assign eret_take = 1'b0;
  logic unused_exc;
  assign unused_exc = ^{exc_req, eret_req, epc};
`endif

  assign pc_inc = PC + 32'd4;  // natural 32-bit wrap

  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    npc          = pc_inc;
    flush        = 1'b0;
    if (Reset) begin
      npc          = RESET_PC;
      flush        = 1'b1;
      state_d      = S_RUN;
      pend_valid_d = 1'b0;
      pend_addr_d  = RESET_PC;
    end else if (exc_take) begin
      // Exception/ERET ignore stall and drop any buffered redirect.
      npc          = EXC_VECTOR;
      flush        = 1'b1;
      state_d      = S_RUN;
      pend_valid_d = 1'b0;
    end else if (eret_take) begin
      npc          = epc;
      flush        = 1'b1;
      state_d      = S_RUN;
      pend_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_PEND: begin
          if (stall) begin
            npc = PC;  // pend_addr kept; further br_req is illegal here
          end else begin
            npc          = pend_addr_q;
            pend_valid_d = 1'b0;
            state_d      = S_RUN;
          end
        end
        default: begin  // S_RUN and S_HOLD behave identically on inputs
          if (stall) begin
            npc = PC;
            if (br_req) begin
              pend_addr_d  = br_target;
              pend_valid_d = 1'b1;
              state_d      = S_PEND;
            end else begin
              state_d = S_HOLD;
            end
          end else begin
            npc     = br_req ? br_target : pc_inc;
            state_d = S_RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q      <= state_d;
    pend_valid_q <= pend_valid_d;
    pend_addr_q  <= pend_addr_d;
  end

  assign NPC           = npc;
  assign flush_fd      = flush;
  assign pend_valid    = pend_valid_q;
  assign addr_misalign = |npc[1:0];

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
`ifdef PC_SEQ_EXC_EN
  localparam bit EXC = 1'b1;
`else
  localparam bit EXC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] PC = '0;
  logic        stall = 1'b0;
  logic        br_req = 1'b0;
  logic [31:0] br_target = '0;
  logic        exc_req = 1'b0;
  logic        eret_req = 1'b0;
  logic [31:0] epc = '0;
  logic [31:0] NPC;
  logic        flush_fd;
  logic        pend_valid;
  logic        addr_misalign;

  pc_sequencer dut (
    .clk(clk), .Reset(Reset), .PC(PC), .stall(stall), .br_req(br_req),
    .br_target(br_target), .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
    .NPC(NPC), .flush_fd(flush_fd), .pend_valid(pend_valid),
    .addr_misalign(addr_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] npc;
    logic        fl;
    logic        pv;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;

  // Stimulus legality: no new redirect while one is already buffered and stalled.
  always @(negedge clk)
    if (!Reset) assert (!(pend_valid && stall && br_req && !exc_req && !eret_req))
      else $error("illegal second br_req during pending redirect");

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, got, want);
  endtask

  // One cycle: drive after the edge, push expectation, compare mid-cycle.
  task automatic step(input string tag, input logic [31:0] pc, input bit rst,
                      input bit st, input bit br, input logic [31:0] tgt,
                      input bit ex, input bit er, input logic [31:0] ep,
                      input logic [31:0] e_npc, input bit e_fl, input bit e_pv);
    exp_t e;
    @(posedge clk);
    #1;
    Reset = rst; PC = pc; stall = st; br_req = br; br_target = tgt;
    exc_req = ex; eret_req = er; epc = ep;
    e.tag = tag; e.npc = e_npc; e.fl = e_fl; e.pv = e_pv; e.mis = |e_npc[1:0];
    q.push_back(e);
    @(negedge clk);
    n_chk++;
    assert (q.size() != 0) n_pass++;
    else $error("FAIL %s: scoreboard empty got %0d want 1", tag, q.size());
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({e.tag, ".npc"}, NPC, e.npc);
      chk({e.tag, ".flush"}, {31'd0, flush_fd}, {31'd0, e.fl});
      chk({e.tag, ".pend"}, {31'd0, pend_valid}, {31'd0, e.pv});
      chk({e.tag, ".mis"}, {31'd0, addr_misalign}, {31'd0, e.mis});
    end
  endtask

  initial begin
    logic [31:0] p;
    //     tag        PC            rst st br tgt          ex er epc          NPC           fl pv
    step("rst0",     32'h0,        1, 0, 0, 32'h0,       0, 0, 32'h0,       32'h3000,     1, 0);
    step("seq0",     32'h3000,     0, 0, 0, 32'h0,       0, 0, 32'h0,       32'h3004,     0, 0);
    step("seq1",     32'h3004,     0, 0, 0, 32'h0,       0, 0, 32'h0,       32'h3008,     0, 0);
    step("seq2",     32'h3008,     0, 0, 0, 32'h0,       0, 0, 32'h0,       32'h300C,     0, 0);
    step("seq3",     32'h300C,     0, 0, 0, 32'h0,       0, 0, 32'h0,       32'h3010,     0, 0);
    step("rstmid",   32'h3010,     1, 0, 0, 32'h0,       0, 0, 32'h0,       32'h3000,     1, 0);
    step("post0",    32'h3000,     0, 0, 0, 32'h0,       0, 0, 32'h0,       32'h3004,     0, 0);
    step("post1",    32'h3004,     0, 0, 0, 32'h0,       0, 0, 32'h0,       32'h3008,     0, 0);
    step("br",       32'h3008,     0, 0, 1, 32'h3040,    0, 0, 32'h0,       32'h3040,     0, 0);
    step("brnext",   32'h3040,     0, 0, 0, 32'h0,       0, 0, 32'h0,       32'h3044,     0, 0);
    // branch arriving under a 3-cycle stall is buffered
    step("stbr",     32'h300C,     0, 1, 1, 32'h3080,    0, 0, 32'h0,       32'h300C,     0, 0);
    step("st2",      32'h300C,     0, 1, 0, 32'h0,       0, 0, 32'h0,       32'h300C,     0, 1);
    step("st3",      32'h300C,     0, 1, 0, 32'h0,       0, 0, 32'h0,       32'h300C,     0, 1);
    step("strel",    32'h300C,     0, 0, 0, 32'h0,       0, 0, 32'h0,       32'h3080,     0, 1);
    step("pdone",    32'h3080,     0, 0, 0, 32'h0,       0, 0, 32'h0,       32'h3084,     0, 0);
    // HOLD then branch under stall, then HOLD released with a live branch
    step("hold",     32'h3084,     0, 1, 0, 32'h0,       0, 0, 32'h0,       32'h3084,     0, 0);
    step("holdbr",   32'h3084,     0, 1, 1, 32'h30C0,    0, 0, 32'h0,       32'h3084,     0, 0);
    step("holdrel",  32'h3084,     0, 0, 0, 32'h0,       0, 0, 32'h0,       32'h30C0,     0, 1);
    step("hold2",    32'h30C4,     0, 1, 0, 32'h0,       0, 0, 32'h0,       32'h30C4,     0, 0);
    step("hold2br",  32'h30C4,     0, 0, 1, 32'h3200,    0, 0, 32'h0,       32'h3200,     0, 0);
    // exception while stalled with a pending redirect
    step("xpend",    32'h300C,     0, 1, 1, 32'h3080,    0, 0, 32'h0,       32'h300C,     0, 0);
    step("exc",      32'h300C,     0, 1, 0, 32'h0,       1, 0, 32'h0,
         EXC ? 32'h4180 : 32'h300C, EXC, 1);
    p = EXC ? 32'h4180 : 32'h300C;
    step("xafter",   p,            0, 0, 0, 32'h0,       0, 0, 32'h0,
         EXC ? 32'h4184 : 32'h3080, 0, !EXC);
    p = EXC ? 32'h4184 : 32'h3080;
    step("xafter2",  p,            0, 0, 0, 32'h0,       0, 0, 32'h0,       p + 32'd4,    0, 0);
    // ERET against a simultaneous branch
    step("eret",     32'h3200,     0, 0, 1, 32'h3300,    0, 1, 32'h3024,
         EXC ? 32'h3024 : 32'h3300, EXC, 0);
    // wrap and misalignment
    step("wrap",     32'hFFFF_FFFC, 0, 0, 0, 32'h0,      0, 0, 32'h0,       32'h0,        0, 0);
    step("misal",    32'h3000,     0, 0, 1, 32'h3042,    0, 0, 32'h0,       32'h3042,     0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
